// File: rtl/freq_meter.sv
// freq_meter: measures period and high time of an asynchronous square wave
// in clk cycles, flags loss of signal and reports lock against an expected period.
`timescale 1ns/1ps
module freq_meter #(
    parameter int unsigned      CNT_W      = 20,
    parameter logic [CNT_W-1:0] TIMEOUT    = 20'd1_000_000,
    parameter logic [CNT_W-1:0] EXP_PERIOD = 20'd200,
    parameter logic [CNT_W-1:0] TOL        = 20'd2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t           state, state_d;
    logic             s1, s2, d;
    logic             rise, fall, in_tol;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] h_lat, h_lat_d;
    logic [CNT_W-1:0] period_d, high_time_d;
    logic             meas_valid_d, timeout_d, locked_d;
    logic             prev_ok, prev_ok_d;

    // Edge detection shares one s2/d pair, so rise and fall are mutually exclusive
    // and carry the same latency, which cancels out of every measurement.
    assign rise = s2 & ~d;
    assign fall = ~s2 & d;

    // Absolute deviation check done on whichever ordering keeps the subtraction non-negative.
    assign in_tol = (cnt >= EXP_PERIOD) ? ((cnt - EXP_PERIOD) <= TOL)
                                        : ((EXP_PERIOD - cnt) <= TOL);

    // Synchroniser and edge-detect delay register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            d  <= s2;
        end
    end

    // State and measurement registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            h_lat      <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            locked     <= 1'b0;
            prev_ok    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            h_lat      <= h_lat_d;
            period     <= period_d;
            high_time  <= high_time_d;
            meas_valid <= meas_valid_d;
            timeout    <= timeout_d;
            locked     <= locked_d;
            prev_ok    <= prev_ok_d;
        end
    end

    // Next-state and next-value logic; priority is enable, then rise, then timeout, then fall.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        h_lat_d      = h_lat;
        period_d     = period;
        high_time_d  = high_time;
        meas_valid_d = 1'b0;
        timeout_d    = timeout;
        locked_d     = locked;
        prev_ok_d    = prev_ok;

        if (!enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
            locked_d  = 1'b0;
            prev_ok_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    locked_d  = 1'b0;
                    prev_ok_d = 1'b0;
                    state_d   = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d     = cnt;
                        high_time_d  = h_lat;
                        meas_valid_d = 1'b1;
                        cnt_d        = CNT_W'(1);
                        timeout_d    = 1'b0;
                        prev_ok_d    = in_tol;
                        locked_d     = in_tol & prev_ok;
                    end else if (cnt == TIMEOUT) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        prev_ok_d = 1'b0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt + 1'b1;
                        if (fall) begin
                            h_lat_d = cnt;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed, table-driven checks of freq_meter with hand-computed expectations.
`timescale 1ns/1ps
module tb_freq_meter;

    localparam int unsigned CW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sig_in;
    logic          enable;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          timeout;
    logic          locked;

    freq_meter #(
        .CNT_W     (CW),
        .TIMEOUT   (20'd1000),
        .EXP_PERIOD(20'd200),
        .TOL       (20'd2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .enable    (enable),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .timeout   (timeout),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned per;
        int unsigned hi;
        int unsigned lk;
        int unsigned to;
        int unsigned stamp;
    } meas_t;

    meas_t mq[$];

    // Every cycle with meas_valid high is logged, so a pulse longer than one cycle shows up as extra entries.
    always @(negedge clk) begin
        if (meas_valid === 1'b1)
            mq.push_back('{32'(period), 32'(high_time), 32'(locked), 32'(timeout), cyc});
    end

    typedef struct {
        int unsigned hi;
        int unsigned lo;
        int unsigned valid;
        int unsigned ep;
        int unsigned eh;
        int unsigned el;
    } vec_t;

    vec_t tbl[15];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned last_set = 0;
    int unsigned last_rise = 0;
    int unsigned last_stamp = 0;
    bit          stamp_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int unsigned hi, input int unsigned lo, input int unsigned valid,
                                input int unsigned ep, input int unsigned eh, input int unsigned el);
        vec_t v;
        v.hi = hi; v.lo = lo; v.valid = valid; v.ep = ep; v.eh = eh; v.el = el;
        return v;
    endfunction

    // Drive sig_in to v just after a rising edge and keep it for n clk cycles in total.
    task automatic hold(input logic v, input int unsigned n);
        if (n != 0) begin
            @(posedge clk);
            #1;
            sig_in   = v;
            last_set = cyc;
            repeat (n - 1) @(posedge clk);
        end
    endtask

    // One wave period starting with a rise; the rise completes the previous period's measurement.
    task automatic do_period(input vec_t v, input int unsigned idx);
        meas_t m;
        hold(1'b1, 5);
        last_rise = last_set;
        @(negedge clk);
        if (v.valid != 0) begin
            chk($sformatf("row%0d valid count", idx), 32'(mq.size()), 32'd1);
            if (mq.size() > 0) begin
                m = mq.pop_front();
                chk($sformatf("row%0d period", idx), m.per, v.ep);
                chk($sformatf("row%0d high_time", idx), m.hi, v.eh);
                chk($sformatf("row%0d locked", idx), m.lk, v.el);
                chk($sformatf("row%0d timeout", idx), m.to, 32'd0);
                if (stamp_ok)
                    chk($sformatf("row%0d valid spacing", idx), m.stamp - last_stamp, v.ep);
                last_stamp = m.stamp;
                stamp_ok   = 1'b1;
            end
        end else begin
            chk($sformatf("row%0d no valid", idx), 32'(mq.size()), 32'd0);
            stamp_ok = 1'b0;
        end
        mq.delete();
        hold(1'b1, v.hi - 5);
        hold(1'b0, v.lo);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        bit seen;

        tbl[0]  = mk(100, 100, 0,   0,   0, 0);
        tbl[1]  = mk(100, 100, 1, 200, 100, 0);
        tbl[2]  = mk(100, 100, 1, 200, 100, 1);
        tbl[3]  = mk(150, 100, 1, 200, 100, 1);
        tbl[4]  = mk(100, 100, 1, 250, 150, 0);
        tbl[5]  = mk(100, 100, 1, 200, 100, 0);
        tbl[6]  = mk( 99,  99, 1, 200, 100, 1);
        tbl[7]  = mk(101, 101, 1, 198,  99, 1);
        tbl[8]  = mk(101, 102, 1, 202, 101, 1);
        tbl[9]  = mk( 98,  99, 1, 203, 101, 0);
        tbl[10] = mk( 98,  99, 1, 197,  98, 0);
        tbl[11] = mk(100, 100, 1, 197,  98, 0);
        tbl[12] = mk(100, 100, 1, 200, 100, 0);
        tbl[13] = mk(100, 100, 1, 200, 100, 1);
        tbl[14] = mk(100,   0, 1, 200, 100, 1);

        rst_n  = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset period", 32'(period), 32'd0);
        chk("reset high_time", 32'(high_time), 32'd0);
        chk("reset meas_valid", 32'(meas_valid), 32'd0);
        chk("reset timeout", 32'(timeout), 32'd0);
        chk("reset locked", 32'(locked), 32'd0);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (5) @(posedge clk);

        // Steady 200/100 wave, period change, and the tolerance boundaries.
        for (int i = 0; i < 15; i++) do_period(tbl[i], i);

        // Wave stops low after the last rise: loss of signal after exactly TIMEOUT cycles.
        hold(1'b0, 1);
        seen = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("timeout raised", 32'(seen), 32'd1);
        chk("timeout cycle", cyc, last_rise + 32'd1003);
        chk("timeout locked", 32'(locked), 32'd0);
        chk("timeout no valid", 32'(mq.size()), 32'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("timeout sticky", 32'(timeout), 32'd1);

        // Resume: first rise only re-arms, second rise measures and clears timeout.
        do_period(mk(100, 100, 0, 0, 0, 0), 100);
        chk("timeout held after first rise", 32'(timeout), 32'd1);
        do_period(mk(100, 100, 1, 200, 100, 0), 101);
        do_period(mk(50, 0, 1, 200, 100, 1), 102);

        // enable dropped mid-period for 5 cycles.
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("disable locked", 32'(locked), 32'd0);
        chk("disable period hold", 32'(period), 32'd200);
        chk("disable high_time hold", 32'(high_time), 32'd100);
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        hold(1'b1, 45);
        hold(1'b0, 100);
        chk("disable no valid", 32'(mq.size()), 32'd0);
        mq.delete();
        do_period(mk(100, 100, 0, 0, 0, 0), 103);
        do_period(mk(50, 0, 1, 200, 100, 0), 104);

        // Asynchronous reset in the middle of a high phase.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset period", 32'(period), 32'd0);
        chk("async reset high_time", 32'(high_time), 32'd0);
        chk("async reset meas_valid", 32'(meas_valid), 32'd0);
        chk("async reset timeout", 32'(timeout), 32'd0);
        chk("async reset locked", 32'(locked), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        sig_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b0, 50);
        mq.delete();
        do_period(mk(100, 100, 0, 0, 0, 0), 105);
        do_period(mk(100, 100, 1, 200, 100, 0), 106);
        do_period(mk(100, 100, 1, 200, 100, 1), 107);
        do_period(mk(100, 0, 1, 200, 100, 1), 108);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
